// File: rtl/sensor_mon_pkg.sv
// -----------------------------------------------------------------------------
// sensor_mon_pkg
// Shared types and helpers for the sensor alarm monitor.
//   ch_state_t : per-channel alarm state (NORMAL, PENDING, ALARM_UNACK, ALARM_ACK)
//   CNT_W      : width of the persistence counter (PERSIST is at most 15)
//   ch_width() : index width for n items, never less than 1 bit
// -----------------------------------------------------------------------------
package sensor_mon_pkg;

   typedef enum logic [1:0] {
      NORMAL      = 2'd0,
      PENDING     = 2'd1,
      ALARM_UNACK = 2'd2,
      ALARM_ACK   = 2'd3
   } ch_state_t;

   localparam int CNT_W = 4;

   // A single channel (or a divider of 1) still needs a 1-bit index.
   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sensor_ch_fsm.sv
// -----------------------------------------------------------------------------
// sensor_ch_fsm
// One sensor channel: stored sample, threshold, persistence counter and the
// alarm state machine.
//   clk, reset : system clock, asynchronous active-high reset
//   en         : system enable; low forces NORMAL and clears the counter
//   smp_we     : sample write for this channel (already qualified by the top)
//   thr_we     : threshold write for this channel
//   wr_data    : sample or threshold value
//   ack        : global acknowledge pulse
//   sample     : currently stored sample
//   state      : current FSM state (also serves as the debug view)
// -----------------------------------------------------------------------------
module sensor_ch_fsm
   import sensor_mon_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int PERSIST  = 3,
   parameter int HYST     = 2,
   parameter int THR_INIT = 200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              smp_we,
   input  logic              thr_we,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              ack,
   output logic [DATA_W-1:0] sample,
   output ch_state_t         state
);

   localparam int DW1 = DATA_W + 1;
   localparam logic [DATA_W:0]  HYST_EXT  = DW1'(HYST);
   localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);

   logic [DATA_W-1:0] thr;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] cur_sample;
   logic [DATA_W:0]   sum_ext;
   logic              over;
   logic              clear;

   // Clear looks at the sample as it will be after this edge, so an ack that
   // coincides with a sample write judges the new value. The sum is done one
   // bit wider so sample + HYST cannot wrap. A threshold below HYST would make
   // the subtraction form meaningless, so only a zero reading clears then.
   always_comb begin
      cur_sample = smp_we ? wr_data : sample;
      over       = (wr_data > thr);
      sum_ext    = {1'b0, cur_sample} + HYST_EXT;
      cnt_inc    = cnt + 1'b1;
      if ({1'b0, thr} < HYST_EXT) begin
         clear = (cur_sample == '0);
      end else begin
         clear = (sum_ext <= {1'b0, thr});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample <= '0;
         thr    <= DATA_W'(THR_INIT);
         cnt    <= '0;
         state  <= NORMAL;
      end else begin
         // Threshold only takes effect on the next sample comparison.
         if (thr_we) thr    <= wr_data;
         if (smp_we) sample <= wr_data;

         if (!en) begin
            state <= NORMAL;
            cnt   <= '0;
         end else begin
            case (state)
               NORMAL: begin
                  if (smp_we && over) begin
                     cnt <= CNT_W'(1);
                     if (PERSIST == 1) state <= ALARM_UNACK;
                     else              state <= PENDING;
                  end
               end
               PENDING: begin
                  if (smp_we) begin
                     if (over) begin
                        cnt <= cnt_inc;
                        if (cnt_inc >= PERSIST_C) state <= ALARM_UNACK;
                     end else begin
                        cnt   <= '0;
                        state <= NORMAL;
                     end
                  end
               end
               // Latched: only ack can move the channel out of here.
               ALARM_UNACK: begin
                  if (ack) begin
                     cnt   <= '0;
                     state <= clear ? NORMAL : ALARM_ACK;
                  end
               end
               ALARM_ACK: begin
                  if (smp_we && clear) begin
                     cnt   <= '0;
                     state <= NORMAL;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= NORMAL;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/sensor_alarm_monitor.sv
// -----------------------------------------------------------------------------
// sensor_alarm_monitor
// N-channel sensor alarm monitor: write decode, per-channel alarm FSMs,
// max-reading tree, LED blink divider and LED drive.
//   clk, reset : system clock, asynchronous active-high reset
//   EN         : system on; low forces all channels to NORMAL and LED off
//   wr_valid   : sample write strobe
//   cfg_we     : threshold write strobe (wins over wr_valid)
//   wr_ch      : target channel; values >= N_CH are ignored
//   wr_data    : sample or threshold value
//   ack        : acknowledge pulse for all channels
//   alarm_vec  : bit i set while channel i is ALARM_UNACK or ALARM_ACK
//   led_alarm  : blinking for unacknowledged alarms, steady for acknowledged
//   max_val    : largest stored sample (registered)
//   max_ch     : lowest channel index holding max_val (registered)
//   ch_state   : debug view of every channel FSM, 2 bits per channel
//
// Handshake: wr_valid and cfg_we are single-cycle strobes with no ready; the
// block accepts every strobe on the edge that samples it, so a strobe held
// high for k cycles is k writes.
// -----------------------------------------------------------------------------
module sensor_alarm_monitor
   import sensor_mon_pkg::*;
#(
   parameter  int N_CH      = 4,
   parameter  int DATA_W    = 8,
   parameter  int PERSIST   = 3,
   parameter  int HYST      = 2,
   parameter  int THR_INIT  = 200,
   parameter  int BLINK_DIV = 25_000_000,
   localparam int CH_W      = ch_width(N_CH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                EN,
   input  logic                wr_valid,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                ack,
   output logic [N_CH-1:0]     alarm_vec,
   output logic                led_alarm,
   output logic [DATA_W-1:0]   max_val,
   output logic [CH_W-1:0]     max_ch,
   output logic [2*N_CH-1:0]   ch_state
);

   localparam int BLK_W = ch_width(BLINK_DIV);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   ch_state_t         st  [N_CH];
   logic [DATA_W-1:0] smp [N_CH];

   logic [N_CH-1:0]   unack_vec;
   logic [N_CH-1:0]   ack_vec;
   logic              any_unack;
   logic              any_ack;

   logic [DATA_W-1:0] best_val;
   logic [CH_W-1:0]   best_ch;

   logic [BLK_W-1:0]  blink_cnt;
   logic              blink_phase;

   // Out-of-range channels never match any instance, so those writes vanish.
   // A threshold write in the same cycle suppresses the sample write.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic hit;
      assign hit = (wr_ch == CH_W'(i));

      sensor_ch_fsm #(
         .DATA_W   (DATA_W),
         .PERSIST  (PERSIST),
         .HYST     (HYST),
         .THR_INIT (THR_INIT)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .en      (EN),
         .smp_we  (wr_valid && EN && !cfg_we && hit),
         .thr_we  (cfg_we && hit),
         .wr_data (wr_data),
         .ack     (ack),
         .sample  (smp[i]),
         .state   (st[i])
      );

      assign unack_vec[i]       = (st[i] == ALARM_UNACK);
      assign ack_vec[i]         = (st[i] == ALARM_ACK);
      assign alarm_vec[i]       = unack_vec[i] || ack_vec[i];
      assign ch_state[2*i +: 2] = st[i];
   end

   assign any_unack = |unack_vec;
   assign any_ack   = |ack_vec;

   // Strictly-greater replacement while scanning upward keeps ties on the
   // lowest channel index.
   always_comb begin
      best_val = smp[0];
      best_ch  = '0;
      for (int i = 1; i < N_CH; i++) begin
         if (smp[i] > best_val) begin
            best_val = smp[i];
            best_ch  = CH_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_val <= '0;
         max_ch  <= '0;
      end else begin
         max_val <= best_val;
         max_ch  <= best_ch;
      end
   end

   // The divider only runs while something is unacknowledged, and restarts
   // from phase 0 each time, so a fresh alarm is dark for the first
   // half-period and lit for the second.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         led_alarm   <= 1'b0;
      end else begin
         if (!EN || !any_unack) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + 1'b1;
         end

         if (!EN)            led_alarm <= 1'b0;
         else if (any_unack) led_alarm <= blink_phase;
         else                led_alarm <= any_ack;
      end
   end

endmodule
